// File: rtl/data_stack.sv
// Hardware data stack for the 16-bit stack processor: top and second entries are held in
// dedicated registers, deeper entries spill into a register array, and bounds violations latch a fault.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top_of_stack,
    output logic [WIDTH-1:0] second_of_stack,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int AD = DEPTH - 2;
    localparam int AW = (AD > 1) ? $clog2(AD) : 1;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_PUSH      = 3'd1,
        OP_POP       = 3'd2,
        OP_REPLACE   = 3'd3,
        OP_POP2_PUSH = 3'd4,
        OP_DUP       = 3'd5,
        OP_SWAP      = 3'd6,
        OP_OVER      = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem [AD];

    logic [WIDTH-1:0] top_q, top_d, second_q, second_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic             has1, has2, has3, room;
    logic             underflow, overflow, spill_en;
    logic [AW-1:0]    spill_idx, fill_idx;
    logic [WIDTH-1:0] fill_val;

    assign has1      = depth_q >= DW'(1);
    assign has2      = depth_q >= DW'(2);
    assign has3      = depth_q >= DW'(3);
    assign room      = depth_q <  DW'(DEPTH);
    assign spill_idx = AW'(depth_q - DW'(2));
    assign fill_idx  = AW'(depth_q - DW'(3));
    // Below three entries there is nothing in the array, so the refilled second reads as zero.
    assign fill_val  = has3 ? mem[fill_idx] : '0;

    always_comb begin
        top_d     = top_q;
        second_d  = second_q;
        depth_d   = depth_q;
        fault_d   = fault_q;
        code_d    = code_q;
        underflow = 1'b0;
        overflow  = 1'b0;
        spill_en  = 1'b0;

        case (op_e'(op))
            OP_PUSH: begin
                if (!room) overflow = 1'b1;
                else begin
                    top_d    = din;
                    second_d = top_q;
                    spill_en = has2;
                    depth_d  = depth_q + DW'(1);
                end
            end
            OP_POP: begin
                if (!has1) underflow = 1'b1;
                else begin
                    top_d    = has2 ? second_q : '0;
                    second_d = fill_val;
                    depth_d  = depth_q - DW'(1);
                end
            end
            OP_REPLACE: begin
                if (!has1) underflow = 1'b1;
                else top_d = din;
            end
            OP_POP2_PUSH: begin
                if (!has2) underflow = 1'b1;
                else begin
                    top_d    = din;
                    second_d = fill_val;
                    depth_d  = depth_q - DW'(1);
                end
            end
            OP_DUP: begin
                if (!has1) underflow = 1'b1;
                else if (!room) overflow = 1'b1;
                else begin
                    second_d = top_q;
                    spill_en = has2;
                    depth_d  = depth_q + DW'(1);
                end
            end
            OP_SWAP: begin
                if (!has2) underflow = 1'b1;
                else begin
                    top_d    = second_q;
                    second_d = top_q;
                end
            end
            OP_OVER: begin
                if (!has2) underflow = 1'b1;
                else if (!room) overflow = 1'b1;
                else begin
                    top_d    = second_q;
                    second_d = top_q;
                    spill_en = 1'b1;
                    depth_d  = depth_q + DW'(1);
                end
            end
            default: ;
        endcase

        // Only the first fault's cause is recorded; later ones just keep fault high.
        if (underflow || overflow) begin
            fault_d = 1'b1;
            if (!fault_q) code_d = underflow ? 2'b01 : 2'b10;
        end

        empty_d = (depth_d == '0);
        full_d  = (depth_d == DW'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            top_q    <= '0;
            second_q <= '0;
            depth_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            top_q    <= top_d;
            second_q <= second_d;
            depth_q  <= depth_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset && spill_en) mem[spill_idx] <= second_q;
    end

    assign top_of_stack    = top_q;
    assign second_of_stack = second_q;
    assign depth           = depth_q;
    assign empty           = empty_q;
    assign full            = full_q;
    assign fault           = fault_q;
    assign fault_code      = code_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: a queue-based reference stack predicts every cycle's outputs,
// and each scenario task pushes predictions to a scoreboard and compares them after the clock edge.
module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] top_of_stack, second_of_stack;
    logic [DW-1:0]    depth;
    logic             empty, full, fault;
    logic [1:0]       fault_code;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .op(op), .din(din),
        .top_of_stack(top_of_stack), .second_of_stack(second_of_stack),
        .depth(depth), .empty(empty), .full(full),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] s;
        logic [DW-1:0]    d;
        logic             e;
        logic             f;
        logic             flt;
        logic [1:0]       code;
    } snap_t;

    snap_t            sb [$];
    logic [WIDTH-1:0] mstk [$];
    logic             mfault;
    logic [1:0]       mcode;
    int               n_checks = 0;
    int               n_fail   = 0;

    function automatic void model_reset();
        mstk.delete();
        mfault = 1'b0;
        mcode  = 2'b00;
    endfunction

    function automatic void model_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
        int n;
        logic unf, ovf;
        logic [WIDTH-1:0] tmp;
        n   = mstk.size();
        unf = 1'b0;
        ovf = 1'b0;
        case (o)
            3'd1: if (n == DEPTH) ovf = 1'b1; else mstk.push_back(d);
            3'd2: if (n < 1) unf = 1'b1; else void'(mstk.pop_back());
            3'd3: if (n < 1) unf = 1'b1; else mstk[n-1] = d;
            3'd4: if (n < 2) unf = 1'b1;
                  else begin void'(mstk.pop_back()); mstk[n-2] = d; end
            3'd5: if (n < 1) unf = 1'b1; else if (n == DEPTH) ovf = 1'b1;
                  else mstk.push_back(mstk[n-1]);
            3'd6: if (n < 2) unf = 1'b1;
                  else begin tmp = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = tmp; end
            3'd7: if (n < 2) unf = 1'b1; else if (n == DEPTH) ovf = 1'b1;
                  else mstk.push_back(mstk[n-2]);
            default: ;
        endcase
        if (unf || ovf) begin
            if (!mfault) mcode = unf ? 2'b01 : 2'b10;
            mfault = 1'b1;
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t x;
        int n;
        n      = mstk.size();
        x.t    = (n >= 1) ? mstk[n-1] : '0;
        x.s    = (n >= 2) ? mstk[n-2] : '0;
        x.d    = DW'(n);
        x.e    = (n == 0);
        x.f    = (n == DEPTH);
        x.flt  = mfault;
        x.code = mcode;
        return x;
    endfunction

    function automatic snap_t dut_snap();
        snap_t x;
        x.t = top_of_stack;  x.s = second_of_stack; x.d = depth;
        x.e = empty; x.f = full; x.flt = fault; x.code = fault_code;
        return x;
    endfunction

    function automatic string fmt(input snap_t x);
        return $sformatf("T=%h S=%h D=%0d E=%b F=%b fault=%b code=%b",
                         x.t, x.s, x.d, x.e, x.f, x.flt, x.code);
    endfunction

    // Apply one cycle of stimulus and return #1 after the sampling edge.
    task automatic drive(input logic r, input logic [2:0] o, input logic [WIDTH-1:0] d);
        reset = r; op = o; din = d;
        @(posedge CLK);
        #1;
        reset = 1'b0; op = 3'd0; din = '0;
    endtask

    task automatic reset_dut();
        model_reset();
        drive(1'b1, 3'd0, '0);
    endtask

    task automatic test_reset();
        snap_t got, exp;
        model_reset();
        sb.push_back(model_snap());
        drive(1'b1, 3'd0, '0);
        got = dut_snap(); exp = sb.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset: got %s want %s", fmt(got), fmt(exp));
        end else $display("reset        -> %s", fmt(got));
    endtask

    task automatic test_push_pop();
        int ops [3] = '{1, 1, 2};
        int dat [3] = '{30030, 5, 0};
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            model_op(3'(ops[i]), 16'(dat[i]));
            sb.push_back(model_snap());
            drive(1'b0, 3'(ops[i]), 16'(dat[i]));
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL push_pop #%0d op=%0d: got %s want %s", i, ops[i], fmt(got), fmt(exp));
            end else $display("push_pop #%0d op=%0d din=%h -> %s", i, ops[i], 16'(dat[i]), fmt(got));
        end
    endtask

    task automatic test_alu_ops();
        int ops [4] = '{1, 1, 4, 3};
        int dat [4] = '{7, 3, 10, 16'hFFF5};
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            model_op(3'(ops[i]), 16'(dat[i]));
            sb.push_back(model_snap());
            drive(1'b0, 3'(ops[i]), 16'(dat[i]));
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL alu_ops #%0d op=%0d: got %s want %s", i, ops[i], fmt(got), fmt(exp));
            end else $display("alu_ops #%0d op=%0d din=%h -> %s", i, ops[i], 16'(dat[i]), fmt(got));
        end
    endtask

    // Fill to DEPTH, overflow once, drain completely, then underflow on empty.
    task automatic test_full_empty();
        logic [2:0] o;
        logic [WIDTH-1:0] d;
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            o = (i <= DEPTH) ? 3'd1 : 3'd2;
            d = (i < DEPTH) ? 16'(i + 1) : ((i == DEPTH) ? 16'd99 : 16'd0);
            model_op(o, d);
            sb.push_back(model_snap());
            drive(1'b0, o, d);
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL full_empty #%0d op=%0d: got %s want %s", i, o, fmt(got), fmt(exp));
            end else $display("full_empty #%0d op=%0d din=%h -> %s", i, o, d, fmt(got));
        end
    endtask

    task automatic test_underflow();
        int ops [4] = '{2, 1, 6, 4};
        int dat [4] = '{0, 4, 0, 8};
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            model_op(3'(ops[i]), 16'(dat[i]));
            sb.push_back(model_snap());
            drive(1'b0, 3'(ops[i]), 16'(dat[i]));
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL underflow #%0d op=%0d: got %s want %s", i, ops[i], fmt(got), fmt(exp));
            end else $display("underflow #%0d op=%0d din=%h -> %s", i, ops[i], 16'(dat[i]), fmt(got));
        end
    endtask

    task automatic test_shuffle();
        int ops [9] = '{1, 1, 6, 7, 5, 2, 2, 2, 5};
        int dat [9] = '{1, 2, 0, 0, 0, 0, 0, 0, 0};
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            model_op(3'(ops[i]), 16'(dat[i]));
            sb.push_back(model_snap());
            drive(1'b0, 3'(ops[i]), 16'(dat[i]));
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL shuffle #%0d op=%0d: got %s want %s", i, ops[i], fmt(got), fmt(exp));
            end else $display("shuffle #%0d op=%0d -> %s", i, ops[i], fmt(got));
        end
    endtask

    task automatic test_reset_priority();
        int ops [5] = '{1, 1, 1, 1, 0};
        int dat [5] = '{1, 2, 3, 9, 0};
        logic r;
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            r = (i == 3);
            if (r) model_reset(); else model_op(3'(ops[i]), 16'(dat[i]));
            sb.push_back(model_snap());
            drive(r, 3'(ops[i]), 16'(dat[i]));
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_priority #%0d reset=%b op=%0d: got %s want %s",
                         i, r, ops[i], fmt(got), fmt(exp));
            end else $display("reset_priority #%0d reset=%b op=%0d -> %s", i, r, ops[i], fmt(got));
        end
    endtask

    // Back-to-back random ops, biased toward pushes early so deep spill/fill paths are exercised.
    task automatic test_back_to_back();
        logic [2:0] o;
        logic [WIDTH-1:0] d;
        snap_t got, exp;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            if (i < 60 && $urandom_range(0, 2) == 0) o = 3'd1;
            else o = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            model_op(o, d);
            sb.push_back(model_snap());
            drive(1'b0, o, d);
            got = dut_snap(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back #%0d op=%0d din=%h: got %s want %s", i, o, d, fmt(got), fmt(exp));
            end else $display("back_to_back #%0d op=%0d din=%h -> %s", i, o, d, fmt(got));
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_push_pop();
        test_alu_ops();
        test_full_empty();
        test_underflow();
        test_shuffle();
        test_reset_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
